// File: rtl/brute_force_matcher_perf_pkg.sv
// Shared constants for the matcher performance collector slice.
package brute_force_matcher_perf_pkg;
  localparam int COUNT_W   = 32;
  localparam int DEPTH_DEF = 8;
  localparam int SUM_W_DEF = 48;
  localparam int IDX_W_DEF = 16;
  localparam logic [COUNT_W-1:0] MIN_RESET = 32'hFFFF_FFFF;
endpackage

// File: rtl/brute_force_matcher_perf_fifo.sv
// Synchronous FIFO with a registered first-word-fall-through head.
// Level counts every held entry (storage plus head register); a push is
// accepted when not full or when the head is popped in the same cycle.
module brute_force_matcher_perf_fifo #(
  parameter int WIDTH = 48,
  parameter int DEPTH = 8,
  localparam int PTR_W = $clog2(DEPTH),
  localparam int LVL_W = PTR_W + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  output logic             full,
  input  logic             pop,
  output logic             empty,
  output logic [WIDTH-1:0] head_data,
  output logic [LVL_W-1:0] level
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [LVL_W-1:0] mem_cnt_q, mem_cnt_d;
  logic [LVL_W-1:0] level_q, level_d;
  logic             out_vld_q, out_vld_d;
  logic [WIDTH-1:0] out_data_q, out_data_d;
  logic             pop_ok, push_ok, load;

  // Next-state: accept push/pop, refill the head register from storage.
  always_comb begin
    full       = (level_q == LVL_W'(DEPTH));
    pop_ok     = pop & out_vld_q;
    push_ok    = push & (~full | pop_ok);
    load       = (mem_cnt_q != '0) & (~out_vld_q | pop_ok);
    wr_ptr_d   = wr_ptr_q + PTR_W'(push_ok);
    rd_ptr_d   = rd_ptr_q + PTR_W'(load);
    mem_cnt_d  = mem_cnt_q + LVL_W'(push_ok) - LVL_W'(load);
    level_d    = level_q + LVL_W'(push_ok) - LVL_W'(pop_ok);
    out_vld_d  = out_vld_q;
    out_data_d = out_data_q;
    if (load) begin
      out_vld_d  = 1'b1;
      out_data_d = mem_q[rd_ptr_q];
    end else if (pop_ok) begin
      out_vld_d  = 1'b0;
    end
  end

  // Control and head registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      mem_cnt_q  <= '0;
      level_q    <= '0;
      out_vld_q  <= 1'b0;
      out_data_q <= '0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      mem_cnt_q  <= mem_cnt_d;
      level_q    <= level_d;
      out_vld_q  <= out_vld_d;
      out_data_q <= out_data_d;
    end
  end

  // Storage array write; contents need no reset.
  always_ff @(posedge clk) begin
    if (push_ok) mem_q[wr_ptr_q] <= push_data;
  end

  assign empty     = ~out_vld_q;
  assign head_data = out_data_q;
  assign level     = level_q;

endmodule

// File: rtl/brute_force_matcher_perf_collector.sv
// Consumer of the matcher performance counter: mirrors its arm/stop
// protocol, samples the frozen count, queues {run_idx,count} and keeps
// min/max/sum/run statistics.
module brute_force_matcher_perf_collector
  import brute_force_matcher_perf_pkg::*;
#(
  parameter int DEPTH = DEPTH_DEF,
  parameter int SUM_W = SUM_W_DEF,
  parameter int IDX_W = IDX_W_DEF,
  localparam int LVL_W = $clog2(DEPTH) + 1,
  localparam int OUT_W = IDX_W + COUNT_W
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               enable,
  input  logic               initialize,
  input  logic               stop_count,
  input  logic [COUNT_W-1:0] count,
  input  logic               clear_stats,
  output logic               m_valid,
  input  logic               m_ready,
  output logic [OUT_W-1:0]   m_data,
  output logic [LVL_W-1:0]   fifo_level,
  output logic               overflow,
  output logic [IDX_W-1:0]   runs,
  output logic [COUNT_W-1:0] min_count,
  output logic [COUNT_W-1:0] max_count,
  output logic [SUM_W-1:0]   sum_count
);

  function automatic logic [SUM_W-1:0] sat_add(input logic [SUM_W-1:0] a,
                                               input logic [COUNT_W-1:0] b);
    logic [SUM_W:0] s;
    s = {1'b0, a} + {{(SUM_W + 1 - COUNT_W){1'b0}}, b};
    return s[SUM_W] ? {SUM_W{1'b1}} : s[SUM_W-1:0];
  endfunction

  logic               armed_q, armed_d;
  logic               cap_pend_q, cap_pend_d;
  logic               smp_vld_q, smp_vld_d;
  logic [COUNT_W-1:0] smp_cnt_q, smp_cnt_d;
  logic [IDX_W-1:0]   run_idx_q, run_idx_d;
  logic [IDX_W-1:0]   runs_q, runs_d;
  logic [COUNT_W-1:0] min_q, min_d;
  logic [COUNT_W-1:0] max_q, max_d;
  logic [SUM_W-1:0]   sum_q, sum_d;
  logic               ovf_q, ovf_d;
  logic               fifo_full, fifo_empty, drop;

  // Arm mirror and two-stage capture: stop -> pending -> sample register.
  always_comb begin
    armed_d    = armed_q;
    cap_pend_d = 1'b0;
    smp_vld_d  = cap_pend_q;
    smp_cnt_d  = cap_pend_q ? count : smp_cnt_q;
    if (enable & initialize) begin
      armed_d = 1'b1;
    end else if (enable & armed_q & stop_count) begin
      armed_d    = 1'b0;
      cap_pend_d = 1'b1;
    end
  end

  // Statistics: clear applies first so a coincident sample survives it.
  always_comb begin
    drop      = smp_vld_q & fifo_full & ~(m_valid & m_ready);
    run_idx_d = run_idx_q;
    runs_d    = clear_stats ? '0 : runs_q;
    min_d     = clear_stats ? MIN_RESET : min_q;
    max_d     = clear_stats ? '0 : max_q;
    sum_d     = clear_stats ? '0 : sum_q;
    ovf_d     = clear_stats ? 1'b0 : ovf_q;
    if (smp_vld_q) begin
      run_idx_d = run_idx_q + 1'b1;
      runs_d    = runs_d + 1'b1;
      if (smp_cnt_q < min_d) min_d = smp_cnt_q;
      if (smp_cnt_q > max_d) max_d = smp_cnt_q;
      sum_d     = sat_add(sum_d, smp_cnt_q);
      if (drop) ovf_d = 1'b1;
    end
  end

  // Control and statistics registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      armed_q    <= 1'b1;
      cap_pend_q <= 1'b0;
      smp_vld_q  <= 1'b0;
      run_idx_q  <= '0;
      runs_q     <= '0;
      min_q      <= MIN_RESET;
      max_q      <= '0;
      sum_q      <= '0;
      ovf_q      <= 1'b0;
    end else begin
      armed_q    <= armed_d;
      cap_pend_q <= cap_pend_d;
      smp_vld_q  <= smp_vld_d;
      run_idx_q  <= run_idx_d;
      runs_q     <= runs_d;
      min_q      <= min_d;
      max_q      <= max_d;
      sum_q      <= sum_d;
      ovf_q      <= ovf_d;
    end
  end

  // Sampled count value; qualified by smp_vld_q so it needs no reset.
  always_ff @(posedge clk) begin
    smp_cnt_q <= smp_cnt_d;
  end

  brute_force_matcher_perf_fifo #(
    .WIDTH (OUT_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (smp_vld_q),
    .push_data ({run_idx_q, smp_cnt_q}),
    .full      (fifo_full),
    .pop       (m_ready),
    .empty     (fifo_empty),
    .head_data (m_data),
    .level     (fifo_level)
  );

  assign m_valid   = ~fifo_empty;
  assign overflow  = ovf_q;
  assign runs      = runs_q;
  assign min_count = min_q;
  assign max_count = max_q;
  assign sum_count = sum_q;

endmodule

// File: tb/tb_brute_force_matcher_perf_collector.sv
// Bench for the performance collector: directed protocol steps plus a
// randomized phase, checked against a queue-based reference model.
module tb_brute_force_matcher_perf_collector;
  localparam int DEPTH = 8;
  localparam int SUM_W = 33;
  localparam int IDX_W = 16;
  localparam logic [63:0] SUM_MAX = (64'd1 << SUM_W) - 64'd1;

  logic              clk = 1'b0;
  logic              rst;
  logic              enable, initialize, stop_count, clear_stats, m_ready;
  logic [31:0]       count;
  logic              m_valid, overflow;
  logic [IDX_W+31:0] m_data;
  logic [3:0]        fifo_level;
  logic [IDX_W-1:0]  runs;
  logic [31:0]       min_count, max_count;
  logic [SUM_W-1:0]  sum_count;

  brute_force_matcher_perf_collector #(
    .DEPTH (DEPTH), .SUM_W (SUM_W), .IDX_W (IDX_W)
  ) dut (
    .clk (clk), .rst (rst), .enable (enable), .initialize (initialize),
    .stop_count (stop_count), .count (count), .clear_stats (clear_stats),
    .m_valid (m_valid), .m_ready (m_ready), .m_data (m_data),
    .fifo_level (fifo_level), .overflow (overflow), .runs (runs),
    .min_count (min_count), .max_count (max_count), .sum_count (sum_count)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // Reference model
  logic [IDX_W+31:0] q[$];
  logic [IDX_W-1:0]  m_idx, m_runs;
  logic [31:0]       m_min, m_max;
  logic [SUM_W-1:0]  m_sum;
  bit                m_ovf, m_armed;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic model_reset();
    q.delete();
    m_idx = '0; m_runs = '0; m_min = '1; m_max = '0; m_sum = '0;
    m_ovf = 1'b0; m_armed = 1'b1;
  endtask

  task automatic model_clear();
    m_runs = '0; m_min = '1; m_max = '0; m_sum = '0; m_ovf = 1'b0;
  endtask

  task automatic model_sample(input logic [31:0] v);
    logic [63:0] t;
    if (q.size() < DEPTH) q.push_back({m_idx, v});
    else m_ovf = 1'b1;
    m_idx  = m_idx + 1'b1;
    m_runs = m_runs + 1'b1;
    if (v < m_min) m_min = v;
    if (v > m_max) m_max = v;
    t = 64'(m_sum) + 64'(v);
    m_sum = (t > SUM_MAX) ? SUM_MAX[SUM_W-1:0] : t[SUM_W-1:0];
  endtask

  task automatic check_stats(input string tag);
    chk({tag, ".runs"},  64'(runs),       64'(m_runs));
    chk({tag, ".min"},   64'(min_count),  64'(m_min));
    chk({tag, ".max"},   64'(max_count),  64'(m_max));
    chk({tag, ".sum"},   64'(sum_count),  64'(m_sum));
    chk({tag, ".ovf"},   64'(overflow),   64'(m_ovf));
    chk({tag, ".level"}, 64'(fifo_level), 64'(q.size()));
  endtask

  // One protocol step: control pulse at edge N, frozen count visible between
  // N and N+1, garbage afterwards; optional pop/clear at edge N+2.
  task automatic run_cycle(input bit en, input bit init, input bit stop,
                           input logic [31:0] val, input bit pop_at_push,
                           input bit clr, input string tag);
    bit cap;
    logic [IDX_W+31:0] hd;
    enable = en; initialize = init; stop_count = stop; count = $urandom;
    tick();
    cap = en && !init && m_armed && stop;
    if (en && init) m_armed = 1'b1;
    else if (cap) m_armed = 1'b0;
    initialize = 1'b0; stop_count = 1'b0; enable = 1'b1; count = val;
    tick();
    count = $urandom;
    if (pop_at_push) begin
      m_ready = 1'b1;
      chk({tag, ".pop_valid"}, 64'(m_valid), 64'd1);
      if (q.size() > 0) begin
        hd = q.pop_front();
        chk({tag, ".pop_data"}, 64'(m_data), 64'(hd));
      end
    end
    clear_stats = clr;
    tick();
    clear_stats = 1'b0; m_ready = 1'b0;
    if (clr) model_clear();
    if (cap) model_sample(val);
    check_stats(tag);
  endtask

  task automatic drain(input int n, input string tag);
    int got;
    logic [IDX_W+31:0] exp;
    got = 0;
    m_ready = 1'b1;
    for (int c = 0; c < 100 && got < n; c++) begin
      if (m_valid === 1'b1) begin
        exp = (q.size() > 0) ? q.pop_front() : '1;
        chk({tag, ".data"}, 64'(m_data), 64'(exp));
        got++;
      end
      tick();
    end
    m_ready = 1'b0;
    chk({tag, ".beats"}, 64'(got), 64'(n));
    tick();
    chk({tag, ".level"}, 64'(fifo_level), 64'(q.size()));
    chk({tag, ".valid"}, 64'(m_valid), 64'(q.size() > 0));
  endtask

  initial begin
    rst = 1'b1; enable = 1'b0; initialize = 1'b0; stop_count = 1'b0;
    clear_stats = 1'b0; m_ready = 1'b0; count = '0;
    repeat (3) tick();
    rst = 1'b0;
    model_reset();
    tick();
    chk("reset.valid", 64'(m_valid), 64'd0);
    chk("reset.data",  64'(m_data),  64'd0);
    check_stats("reset");

    // Single run straight after reset
    run_cycle(1, 0, 1, 32'd100, 0, 0, "t1");
    tick();
    chk("t1.valid", 64'(m_valid), 64'd1);
    chk("t1.head",  64'(m_data),  64'({16'd0, 32'd100}));
    chk("t1.sum",   64'(sum_count), 64'd100);
    drain(1, "t1d");

    // Three runs with initialize between, after a stats clear
    run_cycle(1, 0, 0, 0, 0, 1, "t2clr");
    run_cycle(1, 1, 0, 0, 0, 0, "t2a0");
    run_cycle(1, 0, 1, 32'd50, 0, 0, "t2r0");
    run_cycle(1, 1, 0, 0, 0, 0, "t2a1");
    run_cycle(1, 0, 1, 32'd300, 0, 0, "t2r1");
    run_cycle(1, 1, 0, 0, 0, 0, "t2a2");
    run_cycle(1, 0, 1, 32'd10, 0, 0, "t2r2");
    chk("t2.min", 64'(min_count), 64'd10);
    chk("t2.max", 64'(max_count), 64'd300);
    chk("t2.sum", 64'(sum_count), 64'd360);
    drain(3, "t2d");

    // Disarmed / init-coincident / disabled stops must not capture
    run_cycle(1, 0, 1, 32'd999, 0, 0, "t3nostop");
    run_cycle(1, 1, 1, 32'd998, 0, 0, "t3initstop");
    run_cycle(0, 0, 1, 32'd997, 0, 0, "t3disabled");
    chk("t3.runs", 64'(runs), 64'd3);
    run_cycle(1, 0, 1, 32'd5, 0, 0, "t3armed");
    drain(1, "t3d");

    // Fill past capacity with m_ready low
    run_cycle(1, 0, 0, 0, 0, 1, "t4clr");
    for (int i = 0; i < 9; i++) begin
      run_cycle(1, 1, 0, 0, 0, 0, "t4arm");
      run_cycle(1, 0, 1, 32'(1000 + i), 0, 0, "t4run");
    end
    chk("t4.level", 64'(fifo_level), 64'd8);
    chk("t4.ovf",   64'(overflow),   64'd1);
    chk("t4.runs",  64'(runs),       64'd9);
    repeat (3) tick();
    chk("t4.hold_valid", 64'(m_valid), 64'd1);
    chk("t4.hold_data",  64'(m_data),  64'(q[0]));

    // Full FIFO: pop coincident with push, no overflow
    run_cycle(1, 0, 0, 0, 0, 1, "t5clr");
    run_cycle(1, 1, 0, 0, 0, 0, "t5arm");
    run_cycle(1, 0, 1, 32'd77, 1, 0, "t5");
    chk("t5.level", 64'(fifo_level), 64'd8);
    chk("t5.ovf",   64'(overflow),   64'd0);
    drain(8, "t5d");

    // Sum saturation at SUM_W=33 and clear coincident with a sample
    run_cycle(1, 0, 0, 0, 0, 1, "t6clr");
    for (int i = 0; i < 3; i++) begin
      run_cycle(1, 1, 0, 0, 0, 0, "t6arm");
      run_cycle(1, 0, 1, 32'hFFFF_FFFF, 0, 0, "t6run");
      if (i == 1) chk("t6.sum2", 64'(sum_count), 64'h1_FFFF_FFFE);
    end
    chk("t6.sum3", 64'(sum_count), 64'h1_FFFF_FFFF);
    run_cycle(1, 1, 0, 0, 0, 0, "t6arm");
    run_cycle(1, 0, 1, 32'd7, 0, 1, "t6clrcap");
    chk("t6.runs", 64'(runs), 64'd1);
    chk("t6.sum",  64'(sum_count), 64'd7);
    drain(4, "t6d");

    // Reset while a capture is pending
    run_cycle(1, 1, 0, 0, 0, 0, "t7arm");
    enable = 1'b1; stop_count = 1'b1; count = $urandom;
    tick();
    stop_count = 1'b0; count = 32'd5;
    #2 rst = 1'b1;
    #2 rst = 1'b0;
    model_reset();
    repeat (4) tick();
    chk("t7.valid", 64'(m_valid), 64'd0);
    check_stats("t7");

    // Randomized protocol traffic
    for (int i = 0; i < 40; i++) begin
      int r, rv;
      logic [31:0] v;
      r  = $urandom_range(0, 9);
      rv = $urandom_range(0, 3);
      v  = (rv == 0) ? 32'd0 : (rv == 1) ? 32'hFFFF_FFFF : 32'($urandom);
      run_cycle(r != 9, r < 3, r >= 2, v, 0, $urandom_range(0, 7) == 0, "rnd");
      if (q.size() >= DEPTH - 1 && $urandom_range(0, 1) == 1) drain(q.size(), "rnd_d");
    end
    drain(q.size(), "final");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
